spi_wave_cmd_rx: RTL and testbench
==================================

# spi_wave_cmd_rx

SPI peripheral (mode 0) on the FPGA client that receives waveform commands from the host MCU and drives the waveform generator's `selector` and frequency-step inputs. It samples the asynchronous SPI pins into the system clock domain, decodes fixed 24-bit command frames, and commits register updates atomically at frame end. It optionally shifts current settings back on MISO.

## Interface
- `FRAME_BITS`, 24: bits per valid frame (8-bit command + 16-bit data).
- `SEL_RESET`, 4'b0100: reset value of `selector` (sine).
- `STEP_RESET`, 16'h0100: reset value of `freq_step`.
- `clk` in 1: system clock; sole clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sclk` in 1: SPI clock from host, asynchronous to `clk`.
- `cs_n` in 1: SPI chip select, active-low, asynchronous.
- `mosi` in 1: SPI data in, MSB first.
- `miso` out 1: SPI data out, MSB first.
- `selector` out 4: waveform select to generator.
- `freq_step` out 16: phase-accumulator increment to generator.
- `cfg_valid` out 1: one-`clk` pulse when `selector` or `freq_step` is committed.
- `err_cnt` out 4: count of rejected frames, saturating at 15.

## Operation
- `sclk`, `cs_n`, `mosi` each pass through a 2-flop synchronizer. Edges are detected on the synchronized `sclk` and `cs_n`.
- FSM states:
  - IDLE: waits for synchronized `cs_n` falling. Then clears bit counter, loads TX shift register, and goes to SHIFT.
  - SHIFT: on each synchronized `sclk` rise, shifts `mosi` into a 24-bit RX register and increments the counter. The counter saturates at 31. On synchronized `cs_n` rise, goes to COMMIT.
  - COMMIT: lasts one cycle, decodes the frame, then returns to IDLE.
- Decode, valid only when count == 24 exactly. Byte0[7:4] is the opcode; byte0[3:0] is ignored.
  - 0x0 NOP: no update, no pulse.
  - 0x1 SET_SEL: `selector` <= data[3:0]; data[15:4] ignored.
  - 0x2 SET_STEP: `freq_step` <= data.
  - 0xF DEFAULTS: `selector` <= SEL_RESET; `freq_step` <= STEP_RESET.
- `cfg_valid` pulses in the COMMIT cycle for opcodes 0x1, 0x2 and 0xF.
- Errors:
  - A count other than 24 (short, aborted or long frame) increments `err_cnt`; no register changes.
  - An undefined opcode also increments `err_cnt`; no register changes.
- Outputs update only in COMMIT, so the generator never sees a partial value.
- Reset values: `selector`=SEL_RESET, `freq_step`=STEP_RESET, `cfg_valid`=0, `err_cnt`=0, `miso`=0, FSM=IDLE.
- `rst_n` asserted mid-frame aborts the frame immediately. After release the FSM waits for the next `cs_n` falling edge; a frame already in progress is ignored.

## Timing
- Requires `sclk` high and low times each ≥ 4 `clk` periods.
- Requires `cs_n` setup to first `sclk` rise of ≥ 4 `clk` periods.
- Requires `cs_n` high between frames for ≥ 4 `clk` periods.
- A `sclk` rise is sampled 2–3 `clk` cycles after the pin edge.
- COMMIT occurs 3 `clk` cycles after the `cs_n` pin rise (2 sync + 1 edge register). Outputs and `cfg_valid` are valid in that cycle.
- A `cs_n` rise and a `sclk` rise detected in the same cycle: the `sclk` edge is counted first, then the frame closes.
- MISO is driven from TX shift-register MSB. It shifts on each synchronized `sclk` fall, so data is stable before the next host rising edge.

## Configuration
- `SPI_READBACK_EN` defined:
  - TX register loads {4'hA, `selector`, `freq_step`} at frame start.
  - The host reads back pre-frame settings while writing.
- `SPI_READBACK_EN` undefined: TX logic is absent and `miso` is tied to 0.

## Structure
- `wavegen_pkg` holds:
  - opcode enum (`OP_NOP`, `OP_SET_SEL`, `OP_SET_STEP`, `OP_DEFAULTS`);
  - FSM state typedef;
  - `FRAME_BITS`, readback marker 4'hA, reset defaults.
- Sub-module `sync2`: 2-flop synchronizer with async active-low reset, reset value parameterized. It is instantiated three times: `cs_n` resets to 1, the others to 0.

## Test plan
- Reset: outputs are `selector`=4'b0100, `freq_step`=16'h0100, `err_cnt`=0, `miso`=0 while `rst_n`=0 and after release.
- Frame 0x10_0003: `selector`=4'b0011 and a single `cfg_valid` pulse 3 cycles after `cs_n` rise; `freq_step` unchanged.
- Frame 0x20_1234: `freq_step`=16'h1234.
  - With readback: MISO during the frame reads 0xA3_0100 (after the prior test).
  - Without readback: MISO reads all zeros.
- 16-bit frame, then 25-bit frame: `err_cnt`=2, no register change, no `cfg_valid`.
- Undefined opcode frame 0x50_FFFF: `err_cnt` increments, outputs unchanged. Then frame 0xF0_0000: defaults restored and `cfg_valid` pulses.
- `rst_n` pulsed low after bit 12 of a SET_STEP frame, then a clean SET_SEL 0x10_0001: the aborted frame has no effect; `selector`=1, `freq_step`=16'h0100.

Source files
------------

// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared types and constants for the SPI waveform command receiver
package wavegen_pkg;

  localparam int         FRAME_BITS = 24;
  localparam logic [4:0] FRAME_CNT  = 5'(FRAME_BITS);
  localparam logic [3:0] RB_MARKER  = 4'hA;
  localparam logic [3:0] SEL_RESET  = 4'b0100;
  localparam logic [15:0] STEP_RESET = 16'h0100;

  typedef enum logic [3:0] {
    OP_NOP      = 4'h0,
    OP_SET_SEL  = 4'h1,
    OP_SET_STEP = 4'h2,
    OP_DEFAULTS = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with a parameterized reset value
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_wave_cmd_rx.sv
// rtl/spi_wave_cmd_rx.sv - SPI mode-0 command receiver driving waveform selector and step
// SPI_READBACK_EN: shift {A, selector, freq_step} out on miso during each frame.
module spi_wave_cmd_rx
  import wavegen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [3:0]  selector,
  output logic [15:0] freq_step,
  output logic        cfg_valid,
  output logic [3:0]  err_cnt
);

  logic sclk_s, cs_s, mosi_s;

  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

  logic       sclk_d, cs_d, armed;
  logic [1:0] settle;
  logic       sclk_rise, cs_fall, cs_rise;

  // armed needs a genuine cs_n high seen after the synchronizers flush, so a
  // frame already running when reset releases is never picked up mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & cs_s);
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  state_e      state;
  logic [4:0]  bit_cnt, cnt_next;
  logic [23:0] rx_sr, rx_next;
  logic [3:0]  err_inc;

  // A sclk edge landing with the cs_n rise is folded in before decoding.
  always_comb begin
    cnt_next = bit_cnt;
    rx_next  = rx_sr;
    if (sclk_rise) begin
      rx_next = {rx_sr[22:0], mosi_s};
      if (bit_cnt != 5'd31) cnt_next = bit_cnt + 5'd1;
    end
  end

  assign err_inc = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;

  // Decode happens on entry to COMMIT so the committed values and cfg_valid
  // are all visible during the COMMIT cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 5'd0;
      rx_sr     <= 24'd0;
      selector  <= SEL_RESET;
      freq_step <= STEP_RESET;
      cfg_valid <= 1'b0;
      err_cnt   <= 4'd0;
    end else begin
      cfg_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed && cs_fall) begin
            bit_cnt <= 5'd0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bit_cnt <= cnt_next;
          rx_sr   <= rx_next;
          if (cs_rise) begin
            state <= ST_COMMIT;
            if (cnt_next != FRAME_CNT) begin
              err_cnt <= err_inc;
            end else begin
              case (opcode_e'(rx_next[23:20]))
                OP_NOP: ;
                OP_SET_SEL: begin
                  selector  <= rx_next[3:0];
                  cfg_valid <= 1'b1;
                end
                OP_SET_STEP: begin
                  freq_step <= rx_next[15:0];
                  cfg_valid <= 1'b1;
                end
                OP_DEFAULTS: begin
                  selector  <= SEL_RESET;
                  freq_step <= STEP_RESET;
                  cfg_valid <= 1'b1;
                end
                default: err_cnt <= err_inc;
              endcase
            end
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [23:0] tx_sr;
  logic        sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr <= 24'd0;
    end else if (state == ST_IDLE && armed && cs_fall) begin
      tx_sr <= {RB_MARKER, selector, freq_step};
    end else if (state == ST_SHIFT && sclk_fall) begin
      tx_sr <= {tx_sr[22:0], 1'b0};
    end
  end

  assign miso = tx_sr[23];
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_wave_cmd_rx.sv
// tb/tb_spi_wave_cmd_rx.sv - self-checking bench for spi_wave_cmd_rx with a frame-level model
module tb_spi_wave_cmd_rx;
  import wavegen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs_n, mosi;
  logic        miso, cfg_valid;
  logic [3:0]  selector, err_cnt;
  logic [15:0] freq_step;

  spi_wave_cmd_rx dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .selector(selector), .freq_step(freq_step),
    .cfg_valid(cfg_valid), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  m_sel;
  logic [15:0] m_step;
  logic [3:0]  m_err;
  int          pulse_cnt, first_idx;
  logic [23:0] rb;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    mosi = b;
    cyc(4);
    rb = {rb[22:0], miso};
    sclk = 1'b1;
    cyc(5);
    sclk = 1'b0;
    cyc(5);
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    pulse_cnt = 0;
    first_idx = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (cfg_valid) begin
        pulse_cnt++;
        if (first_idx < 0) first_idx = k;
      end
    end
    cyc(2);
  endtask

  task automatic send_frame(input logic [63:0] data, input int n);
    rb = 24'd0;
    cs_n = 1'b0;
    cyc(6);
    for (int i = n - 1; i >= 0; i--) shift_bit(data[i]);
    end_frame();
  endtask

  task automatic model_reset();
    m_sel = SEL_RESET;
    m_step = STEP_RESET;
    m_err = 4'd0;
  endtask

  // Frame-level rules: exactly 24 bits with a known opcode commits, anything else counts an error.
  task automatic model_apply(input logic [63:0] data, input int n,
                             output int exp_p, output logic [23:0] exp_rb);
    logic [3:0] op;
    op = data[23:20];
`ifdef SPI_READBACK_EN
    exp_rb = {4'hA, m_sel, m_step};
`else
    exp_rb = 24'd0;
`endif
    exp_p = 0;
    if (n != 24 || !(op inside {4'h0, 4'h1, 4'h2, 4'hF})) begin
      if (m_err != 4'hF) m_err = m_err + 4'd1;
    end else if (op == 4'h1) begin
      m_sel = data[3:0]; exp_p = 1;
    end else if (op == 4'h2) begin
      m_step = data[15:0]; exp_p = 1;
    end else if (op == 4'hF) begin
      m_sel = SEL_RESET; m_step = STEP_RESET; exp_p = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    model_reset();
    cyc(3);
    n_checks++; if (selector !== 4'b0100) begin n_fail++; $display("FAIL reset_sel_in: got %h expected 4", selector); end
    n_checks++; if (freq_step !== 16'h0100) begin n_fail++; $display("FAIL reset_step_in: got %h expected 0100", freq_step); end
    n_checks++; if (err_cnt !== 4'd0 || miso !== 1'b0 || cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_misc_in: got err=%h miso=%b cv=%b expected 0 0 0", err_cnt, miso, cfg_valid); end
    rst_n = 1'b1;
    cyc(6);
    n_checks++; if (selector !== 4'b0100 || freq_step !== 16'h0100) begin n_fail++; $display("FAIL reset_after: got %h/%h expected 4/0100", selector, freq_step); end
    n_checks++; if (err_cnt !== 4'd0 || miso !== 1'b0 || cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_misc_after: got err=%h miso=%b cv=%b expected 0 0 0", err_cnt, miso, cfg_valid); end
  endtask

  task automatic test_set_sel();
    int p; logic [23:0] erb;
    model_apply(64'h100003, 24, p, erb);
    send_frame(64'h100003, 24);
    n_checks++; if (selector !== 4'b0011) begin n_fail++; $display("FAIL set_sel: got %h expected 3", selector); end
    n_checks++; if (freq_step !== 16'h0100) begin n_fail++; $display("FAIL set_sel_step: got %h expected 0100", freq_step); end
    n_checks++; if (pulse_cnt !== 1 || first_idx !== 3) begin n_fail++; $display("FAIL set_sel_pulse: got %0d pulses at %0d expected 1 at 3", pulse_cnt, first_idx); end
  endtask

  task automatic test_set_step();
    int p; logic [23:0] erb;
    model_apply(64'h201234, 24, p, erb);
    send_frame(64'h201234, 24);
    n_checks++; if (freq_step !== 16'h1234 || selector !== 4'b0011) begin n_fail++; $display("FAIL set_step: got %h/%h expected 3/1234", selector, freq_step); end
    n_checks++; if (rb !== erb) begin n_fail++; $display("FAIL readback: got %h expected %h", rb, erb); end
    n_checks++; if (pulse_cnt !== 1) begin n_fail++; $display("FAIL set_step_pulse: got %0d expected 1", pulse_cnt); end
  endtask

  task automatic test_bad_length();
    int p; logic [23:0] erb;
    model_apply(64'h2ABC, 16, p, erb);
    send_frame(64'h2ABC, 16);
    n_checks++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL short_pulse: got %0d expected 0", pulse_cnt); end
    model_apply(64'h1_1000_05, 25, p, erb);
    send_frame(64'h1_1000_05, 25);
    n_checks++; if (err_cnt !== 4'd2) begin n_fail++; $display("FAIL err_two: got %0d expected 2", err_cnt); end
    n_checks++; if (selector !== m_sel || freq_step !== m_step || pulse_cnt !== 0) begin n_fail++; $display("FAIL long_nochange: got %h/%h/%0d expected %h/%h/0", selector, freq_step, pulse_cnt, m_sel, m_step); end
    // 56 bits would wrap a non-saturating 5-bit counter back to 24
    model_apply(64'h00_0000_0000_1009, 56, p, erb);
    send_frame(64'h00_0000_0000_1009, 56);
    n_checks++; if (err_cnt !== m_err || selector !== m_sel || pulse_cnt !== 0) begin n_fail++; $display("FAIL cnt_saturate: got err=%0d sel=%h pulses=%0d expected %0d %h 0", err_cnt, selector, pulse_cnt, m_err, m_sel); end
  endtask

  task automatic test_bad_opcode();
    int p; logic [23:0] erb;
    model_apply(64'h50FFFF, 24, p, erb);
    send_frame(64'h50FFFF, 24);
    n_checks++; if (err_cnt !== m_err || selector !== m_sel || freq_step !== m_step || pulse_cnt !== 0) begin n_fail++; $display("FAIL bad_op: got err=%0d %h/%h pulses=%0d expected %0d %h/%h 0", err_cnt, selector, freq_step, pulse_cnt, m_err, m_sel, m_step); end
    model_apply(64'hF00000, 24, p, erb);
    send_frame(64'hF00000, 24);
    n_checks++; if (selector !== 4'b0100 || freq_step !== 16'h0100 || pulse_cnt !== 1) begin n_fail++; $display("FAIL defaults: got %h/%h pulses=%0d expected 4/0100 1", selector, freq_step, pulse_cnt); end
  endtask

  task automatic test_reset_abort();
    int p; logic [23:0] erb;
    logic [23:0] frm;
    frm = 24'h20BEEF;
    rb = 24'd0;
    cs_n = 1'b0;
    cyc(6);
    for (int i = 23; i >= 12; i--) shift_bit(frm[i]);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    model_reset();
    for (int i = 11; i >= 0; i--) shift_bit(frm[i]);
    end_frame();
    n_checks++; if (freq_step !== 16'h0100 || err_cnt !== 4'd0 || pulse_cnt !== 0) begin n_fail++; $display("FAIL abort_ignored: got %h err=%0d pulses=%0d expected 0100 0 0", freq_step, err_cnt, pulse_cnt); end
    model_apply(64'h100001, 24, p, erb);
    send_frame(64'h100001, 24);
    n_checks++; if (selector !== 4'b0001 || freq_step !== 16'h0100 || pulse_cnt !== 1) begin n_fail++; $display("FAIL after_abort: got %h/%h pulses=%0d expected 1/0100 1", selector, freq_step, pulse_cnt); end
  endtask

  task automatic test_random();
    logic [3:0]  ops [7];
    int          lens [6];
    logic [63:0] data;
    int          n, p;
    logic [23:0] erb;
    ops = '{4'h0, 4'h1, 4'h2, 4'hF, 4'h3, 4'h7, 4'hC};
    lens = '{24, 24, 24, 23, 25, 16};
    for (int it = 0; it < 24; it++) begin
      n = lens[$urandom_range(0, 5)];
      data = {32'($urandom), 32'($urandom)};
      data[23:20] = ops[$urandom_range(0, 6)];
      if (n == 25) data[24:21] = ops[$urandom_range(0, 6)];
      model_apply(data, n, p, erb);
      send_frame(data, n);
      n_checks++; if (selector !== m_sel || freq_step !== m_step) begin n_fail++; $display("FAIL rand_regs[%0d]: got %h/%h expected %h/%h", it, selector, freq_step, m_sel, m_step); end
      n_checks++; if (err_cnt !== m_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %0d expected %0d", it, err_cnt, m_err); end
      n_checks++; if (pulse_cnt !== p) begin n_fail++; $display("FAIL rand_pulse[%0d]: got %0d expected %0d", it, pulse_cnt, p); end
      if (n == 24) begin
        n_checks++; if (rb !== erb) begin n_fail++; $display("FAIL rand_rb[%0d]: got %h expected %h", it, rb, erb); end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_sel();
    test_set_step();
    test_bad_length();
    test_bad_opcode();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
